// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels, occupancy count,
// registered read port with valid strobe and sticky overflow/underflow flags.
module sync_fifo_prog #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int            DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc, full, empty;

  // Flags come from the registered count only, so winc/rinc never reach an output.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  always_comb begin
    wr_acc   = winc & ~full;
    rd_acc   = rinc & ~empty;
    wptr_d   = wptr_q + (ASIZE+1)'(wr_acc);
    rptr_d   = rptr_q + (ASIZE+1)'(rd_acc);
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rvalid_d = rd_acc;
    rdata_d  = rd_acc ? mem_q[rptr_q[ASIZE-1:0]] : rdata_q;
    // Set wins over a coincident clear.
    ovf_d    = (ovf_q & ~err_clr) | (winc & full);
    unf_d    = (unf_q & ~err_clr) | (rinc & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; only accepted writes outside reset touch it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign wfull        = full;
  assign rempty       = empty;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a hand-computed vector table plus
// queue-model/scoreboard sequences for fill, drain, errors, streaming and reset.
module tb_sync_fifo_prog;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst_n, winc, rinc, err_clr;
  logic [DSIZE-1:0] wdata;
  logic [ASIZE:0]   afull_thresh, aempty_thresh;
  logic [DSIZE-1:0] rdata;
  logic             rvalid, wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [ASIZE:0]   count;

  sync_fifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .err_clr(err_clr),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic       m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;
  int         rv_run;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       e;
    int         cnt;
    logic       af, ae, ovf, unf, rv;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; winc = 1'b1; rinc = 1'b1; err_clr = 1'b1; wdata = 8'hEE;
    @(posedge clk); #1;
    rst_n = 1'b1; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    mq.delete(); sb.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00; m_rv = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, (afull_thresh == 0) ? 1 : 0);
  endtask

  // One clock with the given inputs; the queue model predicts, the scoreboard holds read data.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic e);
    logic wa, ra;
    winc = w; wdata = d; rinc = r; err_clr = e;
    wa = w && (mq.size() < DEPTH);
    ra = r && (mq.size() > 0);
    m_ovf = (e ? 1'b0 : m_ovf) | (w && mq.size() == DEPTH);
    m_unf = (e ? 1'b0 : m_unf) | (r && mq.size() == 0);
    if (ra) begin
      m_rd = mq.pop_front();
      sb.push_back(m_rd);
    end
    if (wa) mq.push_back(d);
    m_rv = ra;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    chk("rvalid", rvalid, m_rv);
    if (rvalid) begin
      rv_run++;
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL rdata_unexpected: rvalid with no pending read, rdata=%0h", rdata);
      end else chk("rdata", rdata, sb.pop_front());
    end else chk("rdata_hold", rdata, m_rd);
    chk("count", count, mq.size());
    chk("wfull", wfull, mq.size() == DEPTH);
    chk("rempty", rempty, mq.size() == 0);
    chk("almost_full", almost_full, mq.size() >= afull_thresh);
    chk("almost_empty", almost_empty, mq.size() <= aempty_thresh);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;
    afull_thresh = 5'd3; aempty_thresh = 5'd1;
    rv_run = 0;

    // w d r e | cnt af ae ovf unf rv rd   (afull=3, aempty=1)
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
    tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      winc = tbl[i].w; wdata = tbl[i].d; rinc = tbl[i].r; err_clr = tbl[i].e;
      @(posedge clk); #1;
      winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_afull", i), almost_full, tbl[i].af);
      chk($sformatf("tbl%0d_aempty", i), almost_empty, tbl[i].ae);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), underflow, tbl[i].unf);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
    end

    // Fill to full, overflow, threshold extremes, then drain in order.
    afull_thresh = 5'd14; aempty_thresh = 5'd2;
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    afull_thresh = 5'd17; #1;
    chk("afull_above_depth", almost_full, 0);
    aempty_thresh = 5'd16; #1;
    chk("aempty_at_depth", almost_empty, 1);
    afull_thresh = 5'd14; aempty_thresh = 5'd2;
    rv_run = 0;
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rvalid_run", rv_run, 16);

    // Underflow and clear, including clear coincident with a new underflow.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_set_wins", underflow, 1);

    // Simultaneous ops at full and at empty.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_rw_rdata", rdata, 8'h80);
    chk("full_rw_count", count, 15);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk("empty_rw_count", count, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_rw_rdata", rdata, 8'h99);

    // Streaming at depth 8: pointers wrap, order and count preserved.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'h48 + 8'(i), 1'b1, 1'b0);
    chk("stream_count", count, 8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // afull_thresh = 0 keeps almost_full high even when empty.
    afull_thresh = 5'd0;
    do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    afull_thresh = 5'd14;

    // Reset mid-operation discards stored entries.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_rdata", rdata, 8'hA5);
    chk("post_rst_count", count, 0);
    chk("post_rst_rempty", rempty, 1);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
